seg_scan_ctrl: RTL

//  Time-multiplexes one shared hex-to-7-segment decoder across NDIGITS common-anode digits.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_scan_tick.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   SEG_OFF / AN_OFF : idle pin values (segments dark, all anodes disabled)
//   scan_state_t     : per-slot scan phase (blank gap, then lit digit)
//   SEG_A..SEG_DP    : bit positions inside the {DP,G,F,E,D,C,B,A} segment byte
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;
  // Wide enough for the largest supported digit count; users slice it.
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_tick.sv
// Scan-slot prescaler. A free-running divider counts 0..CLK_DIV-1 and wraps.
//   clk, rst   : clock, async active-high reset (divider restarts at 0)
//   slot_end_o : high on the last cycle of a slot (the cycle the divider wraps)
//   blank_end_o: high on the last cycle of the blank gap at the start of a slot
module seg_scan_tick #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end_o,
  output logic blank_end_o
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIVW-1:0] div_q, div_d;

  assign slot_end_o  = (div_q == DIVW'(CLK_DIV - 1));
  assign blank_end_o = (div_q == DIVW'(BLANK_CYC - 1));

  always_comb begin
    div_d = div_q + DIVW'(1);
    if (slot_end_o) div_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed driver for NDIGITS common-anode 7-segment digits sharing one
// external hex decoder. Double-buffered frame data, blank gaps between digits,
// optional leading-zero suppression, DP owned by this block.
//   clk, rst        : clock, async active-high reset
//   wr_en/wr_data/wr_dp : load pending buffer (nibble i -> digit i, digit 0 rightmost)
//   blank_lead      : live enable for leading-zero suppression
//   dec_code        : nibble of the digit being scanned, to the decoder
//   dec_seg         : decoder result {DP,G..A}; its DP bit is ignored
//   an              : registered active-low anode enables
//   seg             : registered active-high segment drive {DP,G..A}
//   frame_done      : one-cycle pulse on the cycle the scan wraps to digit 0
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4*NDIGITS-1:0]   wr_data,
  input  logic [NDIGITS-1:0]     wr_dp,
  input  logic                   blank_lead,
  output logic [3:0]             dec_code,
  input  logic [7:0]             dec_seg,
  output logic [NDIGITS-1:0]     an,
  output logic [7:0]             seg,
  output logic                   frame_done
);

  localparam int                  IDXW       = $clog2(NDIGITS);
  localparam logic [IDXW-1:0]     IDX_LAST   = IDXW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0]  AN_ALL_OFF = AN_OFF[NDIGITS-1:0];

  scan_state_t            state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [4*NDIGITS-1:0]   pend_data_q, act_data_q;
  logic [NDIGITS-1:0]     pend_dp_q, act_dp_q;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic [7:0]             seg_q, seg_d;

  logic                   slot_end, blank_end, wrap;
  logic [NDIGITS-1:0]     lz_mask, an_sel;
  logic                   zero_run, cur_dp, cur_lz, suppress;
  logic [3:0]             cur_nib;
  // The decoder's DP output is deliberately dropped; DP comes from the frame buffer.
  logic                   dec_dp_unused;

  assign dec_dp_unused = dec_seg[SEG_DP];

  seg_scan_tick #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .slot_end_o  (slot_end),
    .blank_end_o (blank_end)
  );

  // lz_mask[i] = every active nibble from the top digit down to i is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (act_data_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_sel  = AN_ALL_OFF;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_nib   = act_data_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_lz    = lz_mask[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign dec_code = cur_nib;

  // Digit 0 always shows, and a lit DP keeps its digit visible.
  assign suppress   = blank_lead & cur_lz & ~cur_dp & (idx_q != '0);
  assign wrap       = (state_q == ST_SHOW) & slot_end & (idx_q == IDX_LAST);
  assign frame_done = wrap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    an_d    = AN_ALL_OFF;
    seg_d   = SEG_OFF;
    case (state_q)
      ST_BLANK: begin
        if (blank_end) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (!suppress) begin
          an_d                = an_sel;
          seg_d[SEG_DP]       = cur_dp;
          seg_d[SEG_G:SEG_A]  = dec_seg[SEG_G:SEG_A];
        end
        if (slot_end) begin
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      an_q        <= AN_ALL_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (wr_en) begin
        pend_data_q <= wr_data;
        pend_dp_q   <= wr_dp;
      end
      // Commit takes the pending value from before this edge, so a write on
      // the wrap cycle waits for the following frame.
      if (wrap) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
